// File: rtl/fwrisc_mem_arb_pkg.sv
// fwrisc_mem_arb_pkg
// Shared types for the fwrisc memory arbiter: controller state encoding,
// grant encoding and the fixed fetch strobe pattern.
// Optional feature macro used by the arbiter files: FWRISC_MEM_ARB_RR_EN.
package fwrisc_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] FETCH_STRB = 4'hf;

endpackage

// File: rtl/fwrisc_mem_arb_sel.sv
// fwrisc_mem_arb_sel
// Combinational winner select between the fetch and data requesters.
// Macro FWRISC_MEM_ARB_RR_EN: when defined, a simultaneous request goes to
// the requester not served last; otherwise data always beats fetch.
// Ports:
//   ivalid_i      fetch request pending
//   dvalid_i      data request pending
//   last_grant_i  requester served by the previous grant (round-robin only)
//   win_o         selected requester (meaningful only when a valid is set)
import fwrisc_mem_arb_pkg::*;

module fwrisc_mem_arb_sel (
  input  logic       ivalid_i,
  input  logic       dvalid_i,
  input  arb_grant_e last_grant_i,
  output arb_grant_e win_o
);

  always_comb begin
    win_o = GRANT_D;
`ifdef FWRISC_MEM_ARB_RR_EN
    if (ivalid_i && dvalid_i) begin
      win_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (ivalid_i) begin
      win_o = GRANT_I;
    end
`else
    if (ivalid_i && !dvalid_i) begin
      win_o = GRANT_I;
    end
`endif
  end

`ifndef FWRISC_MEM_ARB_RR_EN
  // Fixed priority has no history; the input is kept for a uniform port list.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
// Shares one external memory port between the fwrisc fetch and data
// interfaces. A granted request is registered onto the m* port and held
// until accepted; read data returns through a registered one-cycle ready
// pulse. One transaction is outstanding at a time.
// Macro FWRISC_MEM_ARB_RR_EN: round-robin arbitration (else data over fetch).
//
// Handshake: a requester raises *valid and holds it (with its payload) until
// its *ready pulse. The memory side transfers on any cycle with
// mvalid && mready; mready while mvalid=0 is ignored.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   iaddr/ivalid            fetch request;  idata/iready  fetch completion
//   daddr/dwdata/dstrb/
//   dwrite/dvalid           data request;   drdata/dready data completion
//   maddr/mwdata/mstrb/
//   mwrite/mvalid           registered memory request
//   mready/mrdata           memory accept and read data
//   dbg_state               current controller state (arb_state_e encoding)
import fwrisc_mem_arb_pkg::*;

module fwrisc_mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic                  ivalid,
  output logic [31:0]           idata,
  output logic                  iready,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [31:0]           dwdata,
  input  logic [3:0]            dstrb,
  input  logic                  dwrite,
  input  logic                  dvalid,
  output logic [31:0]           drdata,
  output logic                  dready,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [31:0]           mwdata,
  output logic [3:0]            mstrb,
  output logic                  mwrite,
  output logic                  mvalid,
  input  logic                  mready,
  input  logic [31:0]           mrdata,
  output logic [1:0]            dbg_state
);

  arb_state_e            state_q;
  arb_grant_e            grant_q;
  arb_grant_e            last_grant;
  arb_grant_e            win;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [31:0]           mwdata_q;
  logic [3:0]            mstrb_q;
  logic                  mwrite_q;
  logic [31:0]           rdata_q;
  logic                  iready_q;
  logic                  dready_q;

  // Payload of the winning requester, loaded into the m* registers on grant.
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic [31:0]           mwdata_d;
  logic [3:0]            mstrb_d;
  logic                  mwrite_d;

`ifdef FWRISC_MEM_ARB_RR_EN
  arb_grant_e last_grant_q;
  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_D;
`endif

  fwrisc_mem_arb_sel u_sel (
    .ivalid_i     (ivalid),
    .dvalid_i     (dvalid),
    .last_grant_i (last_grant),
    .win_o        (win)
  );

  always_comb begin
    maddr_d  = daddr;
    mwdata_d = dwdata;
    mstrb_d  = dstrb;
    mwrite_d = dwrite;
    if (win == GRANT_I) begin
      // Fetches are full-word reads; write data is zeroed.
      maddr_d  = iaddr;
      mwdata_d = 32'h0;
      mstrb_d  = FETCH_STRB;
      mwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_I;
`ifdef FWRISC_MEM_ARB_RR_EN
      last_grant_q <= GRANT_D;
`endif
      maddr_q      <= '0;
      mwdata_q     <= 32'h0;
      mstrb_q      <= 4'h0;
      mwrite_q     <= 1'b0;
      rdata_q      <= 32'h0;
      iready_q     <= 1'b0;
      dready_q     <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses.
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ivalid || dvalid) begin
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            mstrb_q      <= mstrb_d;
            mwrite_q     <= mwrite_d;
            grant_q      <= win;
`ifdef FWRISC_MEM_ARB_RR_EN
            last_grant_q <= win;
`endif
            state_q      <= REQ;
          end
        end
        REQ: begin
          // Writes capture mrdata too; the data is simply unused by the core.
          if (mready) begin
            rdata_q  <= mrdata;
            iready_q <= (grant_q == GRANT_I);
            dready_q <= (grant_q == GRANT_D);
            state_q  <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mvalid    = (state_q == REQ);
  assign maddr     = maddr_q;
  assign mwdata    = mwdata_q;
  assign mstrb     = mstrb_q;
  assign mwrite    = mwrite_q;
  assign idata     = rdata_q;
  assign drdata    = rdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign dbg_state = state_q;

endmodule
